// File: rtl/qspi_rx_packer_pkg.sv
// Shared types and lookups for the QSPI receive packer.
// Lane-mode and FSM encodings, samples-per-word helper.
package qspi_pkg;

  typedef enum logic [1:0] {
    LANE_1 = 2'd0,
    LANE_2 = 2'd1,
    LANE_4 = 2'd2
  } lane_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rx_state_e;

  function automatic lane_mode_e decode_lane(
    input logic [1:0] raw
  );
    lane_mode_e m;
    unique case (1'b1)
      (raw == 2'b00): m = LANE_1;
      (raw == 2'b01): m = LANE_2;
      default:        m = LANE_4;
    endcase
    return m;
  endfunction

  function automatic int unsigned spw(
    input lane_mode_e  m,
    input int unsigned w
  );
    int unsigned n;
    unique case (1'b1)
      (m == LANE_1): n = w;
      (m == LANE_2): n = w / 2;
      default:       n = w / 4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/qspi_rx_packer_if.sv
// Bundle between the QSPI controller / read buffer and the packer.
// master drives strobes and buffer status, slave is the packer.
interface qspi_rx_packer_if #(
  parameter int WORD_W    = 32,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
);
  logic              start_in;
  logic [CNT_W-1:0]  word_cnt_in;
  logic [1:0]        lane_mode_in;
  logic              sample_en_in;
  logic [3:0]        io_in;
  logic              abort_in;
  logic              fifo_full_in;
  logic [WORD_W-1:0] wr_data_out;
  logic              wr_en_out;
  logic              hold_sclk_out;
  logic              busy_out;
  logic              done_out;
  logic              overrun_out;

  modport master (
    output start_in, word_cnt_in, lane_mode_in,
    output sample_en_in, io_in, abort_in,
    output fifo_full_in,
    input  wr_data_out, wr_en_out, hold_sclk_out,
    input  busy_out, done_out, overrun_out
  );

  modport slave (
    input  start_in, word_cnt_in, lane_mode_in,
    input  sample_en_in, io_in, abort_in,
    input  fifo_full_in,
    output wr_data_out, wr_en_out, hold_sclk_out,
    output busy_out, done_out, overrun_out
  );
endinterface

// File: rtl/qspi_rx_packer_shifter.sv
// Lane-select shift register and sample counter; emits packed word.
// QSPI_RX_BYTE_SWAP_EN selects big-endian byte order.
module qspi_rx_shifter
  import qspi_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift,
  input  lane_mode_e        mode,
  input  logic [3:0]        io,
  output logic              word_complete,
  output logic [WORD_W-1:0] word
);

  localparam int CW = $clog2(WORD_W);

  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] sreg_nx;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     last;

  always_comb begin
    sreg_nx = sreg;
    unique case (1'b1)
      (mode == LANE_1): sreg_nx = {sreg[WORD_W-2:0], io[1]};
      (mode == LANE_2): sreg_nx = {sreg[WORD_W-3:0], io[1:0]};
      default:          sreg_nx = {sreg[WORD_W-5:0], io};
    endcase
  end

  assign last          = CW'(spw(mode, WORD_W) - 1);
  assign word_complete = shift && (cnt == last);

  // Stream order has the first byte in the top lane of sreg.
  always_comb begin
    word = sreg_nx;
`ifndef QSPI_RX_BYTE_SWAP_EN
    for (int b = 0; b < WORD_W / 8; b++) begin
      word[8*b +: 8] = sreg_nx[WORD_W-8-8*b +: 8];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (clear) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (shift) begin
      sreg <= sreg_nx;
      cnt  <= word_complete ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/qspi_rx_packer.sv
// QSPI receive packer: FSM, pending word, burst count, overrun.
// Build option QSPI_RX_BYTE_SWAP_EN: big-endian word packing.
module qspi_rx_packer
  import qspi_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input logic              h_clk,
  input logic              h_rstn,
  qspi_rx_packer_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAXW = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  rx_state_e         state;
  rx_state_e         state_nx;
  lane_mode_e        mode_q;
  logic [CNT_W-1:0]  target_q;
  logic [CNT_W-1:0]  words_rcvd;
  logic [CNT_W-1:0]  words_wr;
  logic [CNT_W-1:0]  clamp;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word;
  logic              pend;
  logic              overrun;
  logic              word_complete;
  logic              hold;
  logic              accept;
  logic              wr_en;
  logic              start_ok;
  logic              last_word;
  logic              drop;

  assign hold  = pend && bus.fifo_full_in;
  assign wr_en = pend && !bus.fifo_full_in && !bus.abort_in;

  assign start_ok = bus.start_in && (state == IDLE) && !bus.abort_in;

  assign accept = bus.sample_en_in && (state == RECV)
               && !hold && !bus.abort_in;

  assign drop = bus.sample_en_in && (state == RECV) && hold;

  assign clamp = (bus.word_cnt_in > MAXW) ? MAXW : bus.word_cnt_in;

  assign last_word = (words_rcvd == target_q - ONE);

  qspi_rx_shifter #(
    .WORD_W(WORD_W)
  ) u_shifter (
    .clk          (h_clk),
    .rst_n        (h_rstn),
    .clear        (bus.abort_in || start_ok),
    .shift        (accept),
    .mode         (mode_q),
    .io           (bus.io_in),
    .word_complete(word_complete),
    .word         (word)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_nx = (clamp == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (accept && word_complete && last_word) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_en && (words_wr + ONE == target_q)) begin
          state_nx = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.abort_in) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn) begin
      pend       <= 1'b0;
      word_q     <= '0;
      words_rcvd <= '0;
      words_wr   <= '0;
      target_q   <= '0;
      mode_q     <= LANE_1;
    end else if (bus.abort_in) begin
      pend       <= 1'b0;
      words_rcvd <= '0;
      words_wr   <= '0;
      target_q   <= '0;
    end else begin
      if (start_ok) begin
        target_q   <= clamp;
        mode_q     <= decode_lane(bus.lane_mode_in);
        words_rcvd <= '0;
        words_wr   <= '0;
      end
      // A write and a new completion can coincide; completion wins.
      if (accept && word_complete) begin
        word_q     <= word;
        pend       <= 1'b1;
        words_rcvd <= words_rcvd + ONE;
      end else if (wr_en) begin
        pend <= 1'b0;
      end
      if (wr_en) begin
        words_wr <= words_wr + ONE;
      end
    end
  end

  always_ff @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn) begin
      overrun <= 1'b0;
    end else if (!bus.abort_in) begin
      if (start_ok) begin
        overrun <= 1'b0;
      end else if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  assign bus.wr_data_out   = word_q;
  assign bus.wr_en_out     = wr_en;
  assign bus.hold_sclk_out = hold;
  assign bus.busy_out      = (state != IDLE);
  assign bus.done_out      = (state == DONE);
  assign bus.overrun_out   = overrun;

endmodule

// File: doc/qspi_rx_packer.md
Name: qspi_rx_packer

Overview:
- Receive-side assembly stage between the QSPI IO pins and the AHB read buffer (sync FIFO).
- Samples io0..io3 on strobes from the QSPI controller and packs 1/2/4 bits per strobe into 32-bit words.
- Writes each completed word into the read buffer, applying backpressure when the buffer is full.
- Counts words against the AHB burst length, pulses done at the end of the burst, and flags dropped samples.

Parameters:
- WORD_W, 32, width of packed word and FIFO write data.
- MAX_WORDS, 16, largest burst in words (INCR16/WRAP16).
- CNT_W, $clog2(MAX_WORDS+1), width of the word counters.

Ports:
- h_clk  input  1  system clock; all logic on rising edge.
- h_rstn  input  1  asynchronous active-low reset.
- start_in  input  1  one-cycle pulse that begins a receive burst; ignored unless IDLE.
- word_cnt_in  input  CNT_W  words to receive; captured on start_in.
- lane_mode_in  input  2  00=1 line, 01=2 lines, 10=4 lines, 11=4 lines; captured on start_in.
- sample_en_in  input  1  one-cycle strobe: io_in is valid this cycle (sclk sample edge).
- io_in  input  4  {io3,io2,io1,io0} input values.
- abort_in  input  1  terminates the burst immediately.
- fifo_full_in  input  1  read buffer full.
- wr_data_out  output  WORD_W  packed word to read buffer.
- wr_en_out  output  1  read buffer write strobe.
- hold_sclk_out  output  1  asks the QSPI controller to suspend sclk/sample strobes.
- busy_out  output  1  high when not IDLE.
- done_out  output  1  one-cycle pulse after the last word is written.
- overrun_out  output  1  sticky; set when a sample is dropped, cleared on start_in.

Behaviour:
- Reset values: all outputs 0, state IDLE, shift register 0, counters 0, pend 0.
- States and transitions:
  - IDLE -> RECV on start_in. Captures word_cnt_in, clamped to MAX_WORDS, and lane_mode_in. Clears overrun_out.
  - IDLE -> DONE on start_in with word_cnt_in=0. No writes occur.
  - RECV -> DRAIN when the final sample of the last word is accepted.
  - DRAIN -> DONE when the pending word is written.
  - DONE -> IDLE after one cycle. done_out=1 only while in DONE.
  - abort_in in any state: IDLE at the next edge. pend, shift register and counters are cleared. No write and no done_out are produced. abort_in has priority over every other input.
- Lane shifting, per accepted sample, MSB-first within each byte:
  - 1 line: io1 (MISO), 8 samples per byte.
  - 2 lines: {io1,io0}, io1 more significant, 4 samples per byte.
  - 4 lines: {io3,io2,io1,io0}, io3 most significant, 2 samples per byte.
  - Samples per word are therefore 32, 16 or 8.
- Byte packing: the first byte received goes to wr_data_out[7:0] and the fourth to [31:24] (little-endian, AHB order).
- A sample is accepted when sample_en_in=1, state is RECV, and NOT (pend=1 and fifo_full_in=1).
- Completion and write:
  - The sample that completes a word loads the word register and sets pend at the clock edge.
  - wr_en_out = pend AND NOT fifo_full_in (combinational). A write clears pend and increments words_written.
  - Earliest write is one cycle after the completing sample.
- Hold: hold_sclk_out = pend AND fifo_full_in.
  - A sample strobe arriving while hold_sclk_out=1 is dropped. overrun_out is set and the shift state is unchanged.
- Simultaneous events:
  - A write of the pending word and acceptance of a new sample in the same cycle are both permitted.
  - start_in while busy is ignored.
  - sample_en_in outside RECV is ignored and does not set overrun_out.
- Arithmetic: the sample counter wraps at samples-per-word. Words written are compared to the captured count with CNT_W-bit unsigned compare.

Optional Feature:
- Macro: QSPI_RX_BYTE_SWAP_EN.
- When defined, words are packed big-endian: the first byte goes to [31:24] and the fourth to [7:0], for flashes with word-ordered data.
- When undefined, packing is little-endian as in Behaviour. Ports are identical in both builds.

Decomposition:
- Package qspi_pkg:
  - lane_mode_e enum (LANE_1, LANE_2, LANE_4).
  - rx_state_e enum (IDLE, RECV, DRAIN, DONE).
  - Constant samples-per-word lookup per lane mode.
- Sub-module qspi_rx_shifter:
  - Contains the lane-select shift register and the byte/sample counter.
  - Outputs word_complete and the packed word.
- The parent contains the FSM, pend, word counter, FIFO handshake and overrun logic.

Test Plan:
1. Quad, 1 word: 8 strobes with io_in = 1,2,3,4,5,6,7,8 and fifo not full -> one wr_en_out with wr_data_out=32'h78563412, then done_out pulse; busy_out low after.
2. Single line, word_cnt=2: 64 strobes driving io1 with bytes A5,5A,FF,00,01,02,03,04 -> writes 32'h00FF5AA5 then 32'h04030201, then done_out.
3. Backpressure: 4-line word completes while fifo_full_in=1 -> hold_sclk_out=1, no write; full drops for 1 cycle -> single write, hold clears; strobe during hold -> overrun_out=1 and the next word is still correct minus the dropped nibble.
4. abort_in mid-word (after 3 of 8 quad strobes) -> IDLE next cycle, no wr_en_out, no done_out; a new start then packs the next 8 strobes correctly from byte 0.
5. word_cnt_in=0 -> done_out exactly 2 cycles after start_in, no writes. word_cnt_in=31 -> clamped, exactly 16 writes.
6. QSPI_RX_BYTE_SWAP_EN defined, rerun scenario 1 -> wr_data_out=32'h12345678.
